ooo_resp_scheduler: RTL and testbench

Slave-side response scheduler for the out-of-order read/write protocol on `dut_if`. It accepts write and read requests tagged with 4-bit IDs into per-channel outstanding tables and services them against a 256x8 memory. It returns write and read responses out of order, using an address-derived latency and a round-robin pick. Same-ID requests stay in order. It is the reference slave that drives `wr_rdy`/`rd_rdy` and both response channels.

---
 rtl/ooo_resp_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_ooo_resp_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ooo_resp_scheduler.sv
// Out-of-order response slave: per-channel outstanding tables with address-derived latency,
// same-ID ordering via dependency masks, and round-robin issue against a 256x8 memory.
module ooo_resp_scheduler #(
  parameter int         DEPTH    = 4,
  parameter int         LAT_BITS = 3,
  parameter logic [7:0] ERR_BASE = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] awid,
  output logic       wr_rdy,
  output logic       wr_resp_valid,
  output logic [3:0] wr_resp_id,
  output logic [1:0] wr_resp,
  input  logic       rd_valid,
  input  logic [7:0] rd_addr,
  input  logic [3:0] arid,
  output logic       rd_rdy,
  output logic       rd_resp_valid,
  output logic [3:0] rd_resp_id,
  output logic [1:0] rd_resp,
  output logic [7:0] rd_data
);
  localparam int         IW     = $clog2(DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef logic [DEPTH-1:0] mask_t;

  // First set bit at or after rr with wrap-around; MSB flags that a grant exists.
  function automatic logic [IW:0] rr_pick(input mask_t elig, input logic [IW-1:0] rr);
    logic [IW:0] pick;
    int          idx;
    pick = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % DEPTH;
      if (elig[idx[IW-1:0]]) pick = {1'b1, idx[IW-1:0]};
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] first_free(input mask_t vld);
    logic [IW-1:0] f;
    f = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!vld[i]) f = IW'(i);
    return f;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (int'(g) == DEPTH - 1) ? '0 : g + 1'b1;
  endfunction

  mask_t               w_vld, r_vld;
  logic [3:0]          w_id  [DEPTH];
  logic [3:0]          r_id  [DEPTH];
  logic [1:0]          w_rsp [DEPTH];
  logic [1:0]          r_rsp [DEPTH];
  logic [7:0]          r_dat [DEPTH];
  logic [LAT_BITS-1:0] w_cnt [DEPTH];
  logic [LAT_BITS-1:0] r_cnt [DEPTH];
  mask_t               w_dep [DEPTH];
  mask_t               r_dep [DEPTH];
  logic [IW-1:0]       w_rr, r_rr;
  logic [7:0]          mem [256];

  mask_t         w_elig, r_elig, w_dep_new, r_dep_new;
  logic [IW:0]   w_pick, r_pick;
  logic          w_gnt, r_gnt, w_acc, r_acc;
  logic [IW-1:0] w_gidx, r_gidx, w_aidx, r_aidx;

  assign wr_rdy = ~&w_vld;
  assign rd_rdy = ~&r_vld;
  assign w_acc  = wr_valid && wr_rdy;
  assign r_acc  = rd_valid && rd_rdy;
  assign w_pick = rr_pick(w_elig, w_rr);
  assign r_pick = rr_pick(r_elig, r_rr);
  assign w_gnt  = w_pick[IW];
  assign r_gnt  = r_pick[IW];
  assign w_gidx = w_pick[IW-1:0];
  assign r_gidx = r_pick[IW-1:0];
  assign w_aidx = first_free(w_vld);
  assign r_aidx = first_free(r_vld);

  // An entry issuing on this edge must not become a dependency of the one allocated on it.
  always_comb begin
    w_elig    = '0;
    r_elig    = '0;
    w_dep_new = '0;
    r_dep_new = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i]    = w_vld[i] && (w_cnt[i] == '0) && (w_dep[i] == '0);
      r_elig[i]    = r_vld[i] && (r_cnt[i] == '0) && (r_dep[i] == '0);
      w_dep_new[i] = w_vld[i] && (w_id[i] == awid) && !(w_gnt && (w_gidx == IW'(i)));
      r_dep_new[i] = r_vld[i] && (r_id[i] == arid) && !(r_gnt && (r_gidx == IW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_vld         <= '0;
      w_rr          <= '0;
      wr_resp_valid <= 1'b0;
      wr_resp_id    <= '0;
      wr_resp       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        w_id[i]  <= '0;
        w_rsp[i] <= '0;
        w_cnt[i] <= '0;
        w_dep[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_vld[i] && w_cnt[i] != '0) w_cnt[i] <= w_cnt[i] - 1'b1;
        if (w_gnt) w_dep[i][w_gidx] <= 1'b0;
      end
      wr_resp_valid <= w_gnt;
      wr_resp_id    <= w_gnt ? w_id[w_gidx] : '0;
      wr_resp       <= w_gnt ? w_rsp[w_gidx] : '0;
      if (w_gnt) begin
        w_vld[w_gidx] <= 1'b0;
        w_rr          <= rr_next(w_gidx);
      end
      if (w_acc) begin
        w_vld[w_aidx] <= 1'b1;
        w_id[w_aidx]  <= awid;
        w_rsp[w_aidx] <= (wr_addr < ERR_BASE) ? OKAY : SLVERR;
        w_cnt[w_aidx] <= wr_addr[LAT_BITS-1:0];
        w_dep[w_aidx] <= w_dep_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld         <= '0;
      r_rr          <= '0;
      rd_resp_valid <= 1'b0;
      rd_resp_id    <= '0;
      rd_resp       <= '0;
      rd_data       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]  <= '0;
        r_rsp[i] <= '0;
        r_dat[i] <= '0;
        r_cnt[i] <= '0;
        r_dep[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
        if (r_gnt) r_dep[i][r_gidx] <= 1'b0;
      end
      rd_resp_valid <= r_gnt;
      rd_resp_id    <= r_gnt ? r_id[r_gidx] : '0;
      rd_resp       <= r_gnt ? r_rsp[r_gidx] : '0;
      rd_data       <= r_gnt ? r_dat[r_gidx] : '0;
      if (r_gnt) begin
        r_vld[r_gidx] <= 1'b0;
        r_rr          <= rr_next(r_gidx);
      end
      if (r_acc) begin
        r_vld[r_aidx] <= 1'b1;
        r_id[r_aidx]  <= arid;
        r_rsp[r_aidx] <= (rd_addr < ERR_BASE) ? OKAY : SLVERR;
        r_dat[r_aidx] <= (rd_addr < ERR_BASE) ? mem[rd_addr] : 8'h00;
        r_cnt[r_aidx] <= rd_addr[LAT_BITS-1:0];
        r_dep[r_aidx] <= r_dep_new;
      end
    end
  end

  // Memory is never reset; a same-edge read above sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (w_acc && rst && (wr_addr < ERR_BASE)) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_ooo_resp_scheduler.sv
// Bench for ooo_resp_scheduler: directed scenarios plus random traffic checked against a
// reference model of slots holding absolute due times and arrival order.
module tb_ooo_resp_scheduler;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, rd_valid;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [3:0] awid, arid;
  logic       wr_rdy, rd_rdy, wr_resp_valid, rd_resp_valid;
  logic [3:0] wr_resp_id, rd_resp_id;
  logic [1:0] wr_resp, rd_resp;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  ooo_resp_scheduler #(.DEPTH(DEPTH), .LAT_BITS(3), .ERR_BASE(8'hF0)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .awid(awid), .wr_rdy(wr_rdy),
    .wr_resp_valid(wr_resp_valid), .wr_resp_id(wr_resp_id), .wr_resp(wr_resp),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .arid(arid), .rd_rdy(rd_rdy),
    .rd_resp_valid(rd_resp_valid), .rd_resp_id(rd_resp_id), .rd_resp(rd_resp), .rd_data(rd_data)
  );

  typedef struct {
    bit         v;
    logic [3:0] id;
    logic [1:0] rsp;
    logic [7:0] dat;
    bit         dk;
    int         due;
    int         seq;
  } ent_t;

  ent_t       wtab[DEPTH];
  ent_t       rtab[DEPTH];
  int         wrr, rrr, seqc, ecyc;
  logic [7:0] mem_m[256];
  bit         known[256];
  int         errors = 0;
  int         checks = 0;
  int         wacc_cyc[16], wresp_cyc[16], racc_cyc[16], rresp_cyc[16];
  logic [7:0] robs_dat[16];
  logic [1:0] robs_rsp[16];
  int         id3_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, ecyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      wtab[i].v = 1'b0;
      rtab[i].v = 1'b0;
    end
    wrr = 0;
    rrr = 0;
  endtask

  function automatic bit model_free(input bit is_rd);
    bit f = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (is_rd ? !rtab[i].v : !wtab[i].v) f = 1'b1;
    return f;
  endfunction

  // One edge of one channel: issue the oldest-ready eligible slot round-robin, then allocate.
  task automatic model_chan(input bit is_rd, input bit req, input logic [7:0] addr,
                            input logic [3:0] id, input logic [7:0] dat, input bit dk,
                            output bit acc, output bit gv, output ent_t g);
    ent_t t[DEPTH];
    int   rr, gi, fi, i;
    bit   blocked;
    for (int k = 0; k < DEPTH; k++) t[k] = is_rd ? rtab[k] : wtab[k];
    rr = is_rd ? rrr : wrr;
    gi = -1;
    fi = -1;
    g  = t[0];
    for (int k = 0; k < DEPTH; k++) begin
      i = (rr + k) % DEPTH;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (j != i && t[j].v && t[j].id == t[i].id && t[j].seq < t[i].seq) blocked = 1'b1;
      if (gi < 0 && t[i].v && t[i].due < ecyc && !blocked) gi = i;
    end
    for (int k = DEPTH - 1; k >= 0; k--) if (!t[k].v) fi = k;
    acc = req && (fi >= 0);
    gv  = (gi >= 0);
    if (gv) begin
      g       = t[gi];
      t[gi].v = 1'b0;
      rr      = (gi + 1) % DEPTH;
    end
    if (acc) begin
      t[fi].v   = 1'b1;
      t[fi].id  = id;
      t[fi].rsp = (addr < 8'hF0) ? 2'b00 : 2'b10;
      t[fi].dat = dat;
      t[fi].dk  = dk;
      t[fi].due = ecyc + int'(addr[2:0]);
      t[fi].seq = seqc;
      seqc++;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (is_rd) rtab[k] = t[k];
      else wtab[k] = t[k];
    end
    if (is_rd) rrr = rr;
    else wrr = rr;
  endtask

  task automatic drive_cycle(input bit wv, input logic [7:0] wa, input logic [7:0] wd,
                             input logic [3:0] wid, input bit rv, input logic [7:0] ra,
                             input logic [3:0] rid);
    bit         wacc, racc, wg, rg, rdk;
    ent_t       we, re;
    logic [7:0] rdat;
    check("wr_rdy", wr_rdy, model_free(1'b0));
    check("rd_rdy", rd_rdy, model_free(1'b1));
    wr_valid = wv; wr_addr = wa; wr_data = wd; awid = wid;
    rd_valid = rv; rd_addr = ra; arid = rid;
    ecyc++;
    if (ra >= 8'hF0) begin
      rdat = 8'h00;
      rdk  = 1'b1;
    end else begin
      rdat = mem_m[ra];
      rdk  = known[ra];
    end
    model_chan(1'b0, wv, wa, wid, 8'h00, 1'b1, wacc, wg, we);
    model_chan(1'b1, rv, ra, rid, rdat, rdk, racc, rg, re);
    if (wacc && wa < 8'hF0) begin
      mem_m[wa] = wd;
      known[wa] = 1'b1;
    end
    if (wacc) wacc_cyc[wid] = ecyc;
    if (racc) racc_cyc[rid] = ecyc;
    @(posedge clk);
    @(negedge clk);
    check("wr_resp_valid", wr_resp_valid, wg);
    check("wr_resp_id", wr_resp_id, wg ? we.id : 4'h0);
    check("wr_resp", wr_resp, wg ? we.rsp : 2'b00);
    check("rd_resp_valid", rd_resp_valid, rg);
    check("rd_resp_id", rd_resp_id, rg ? re.id : 4'h0);
    check("rd_resp", rd_resp, rg ? re.rsp : 2'b00);
    if (!rg || re.dk) check("rd_data", rd_data, rg ? re.dat : 8'h00);
    if (wr_resp_valid) begin
      wresp_cyc[wr_resp_id] = ecyc;
      if (wr_resp_id == 4'd3) id3_q.push_back(ecyc);
      $display("edge %0d: wr resp id=%0d resp=%0d", ecyc, wr_resp_id, wr_resp);
    end
    if (rd_resp_valid) begin
      rresp_cyc[rd_resp_id] = ecyc;
      robs_dat[rd_resp_id]  = rd_data;
      robs_rsp[rd_resp_id]  = rd_resp;
      $display("edge %0d: rd resp id=%0d resp=%0d data=%02h", ecyc, rd_resp_id, rd_resp, rd_data);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic wr_only(input logic [7:0] a, input logic [7:0] d, input logic [3:0] id);
    drive_cycle(1'b1, a, d, id, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic rd_only(input logic [7:0] a, input logic [3:0] id);
    drive_cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, a, id);
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    int  t0, lows;
    bit  done;
    for (int i = 0; i < 16; i++) begin
      wacc_cyc[i] = -1000; wresp_cyc[i] = -1000;
      racc_cyc[i] = -1000; rresp_cyc[i] = -1000;
      robs_dat[i] = 8'hFF; robs_rsp[i] = 2'b11;
    end
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; awid = '0;
    rd_valid = 1'b0; rd_addr = '0; arid = '0;
    seqc = 0;
    ecyc = 0;
    rst  = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_wr_resp_valid", wr_resp_valid, 0);
    check("reset_wr_resp_id", wr_resp_id, 0);
    check("reset_wr_resp", wr_resp, 0);
    check("reset_rd_resp_valid", rd_resp_valid, 0);
    check("reset_rd_resp_id", rd_resp_id, 0);
    check("reset_rd_resp", rd_resp, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_wr_rdy", wr_rdy, 1);
    check("reset_rd_rdy", rd_rdy, 1);
    rst = 1'b1;
    model_reset();

    // Reordering: the short-latency write overtakes the long one.
    wr_only(8'h05, 8'h11, 4'd1);
    wr_only(8'h00, 8'h22, 4'd2);
    idle(8);
    check("reorder_id2_latency", wresp_cyc[2] - wacc_cyc[2], 1);
    check("reorder_id1_latency", wresp_cyc[1] - wacc_cyc[1], 6);

    // Same-ID ordering.
    id3_q.delete();
    wr_only(8'h07, 8'h33, 4'd3);
    t0 = ecyc;
    wr_only(8'h00, 8'h44, 4'd3);
    idle(11);
    check("sameid_count", id3_q.size(), 2);
    if (id3_q.size() == 2) begin
      check("sameid_first_latency", id3_q[0] - t0, 8);
      check("sameid_gap", id3_q[1] - id3_q[0], 1);
    end

    // Read-after-write and unmapped read.
    wr_only(8'h10, 8'hA5, 4'd0);
    rd_only(8'h10, 4'd4);
    rd_only(8'hF3, 4'd5);
    idle(6);
    check("raw_data", robs_dat[4], 8'hA5);
    check("raw_resp", robs_rsp[4], 2'b00);
    check("err_resp", robs_rsp[5], 2'b10);
    check("err_data", robs_dat[5], 8'h00);

    // Arbitration tie: three reads all reach zero together; rr sits at index 2 here.
    rd_only(8'h26, 4'd6);
    rd_only(8'h25, 4'd7);
    rd_only(8'h24, 4'd8);
    idle(9);
    check("tie_first_latency", rresp_cyc[8] - racc_cyc[6], 7);
    check("tie_order_a", rresp_cyc[6] - rresp_cyc[8], 1);
    check("tie_order_b", rresp_cyc[7] - rresp_cyc[6], 1);

    // Full write table, then a held fifth request.
    for (int i = 0; i < 4; i++) wr_only(8'h07, 8'(i), 4'(i));
    check("full_rdy_after_fill", wr_rdy, 0);
    lows = 0;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (wr_rdy) done = 1'b1;
      else lows++;
      wr_only(8'h00, 8'h5A, 4'd9);
    end
    check("full_rdy_returned", done, 1);
    check("full_rdy_low_cycles", lows, 5);
    idle(12);

    // Asynchronous reset with reads outstanding and one response on the outputs.
    rd_only(8'h17, 4'd1);
    rd_only(8'h16, 4'd2);
    rd_only(8'h10, 4'd3);
    idle(1);
    #2 rst = 1'b0;
    #1;
    check("midrst_rd_resp_valid", rd_resp_valid, 0);
    check("midrst_rd_resp_id", rd_resp_id, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_rd_rdy", rd_rdy, 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle(12);

    // Random mixed traffic.
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 99) < 60, rand_addr(), 8'($urandom), 4'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 60, rand_addr(), 4'($urandom_range(0, 3)));
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
